pc_ras: RTL and testbench

Parametrised program counter with an integrated return-address stack (RAS): the next-generation replacement for the fixed 16-bit incrementer path in the CPU fetch stage. It holds the current instruction address and advances, loads, clears, calls and returns under single-cycle control. The RAS overwrites its oldest entry on overflow, and underflow and overflow are reported as sticky flags. It sits between the control unit (jump/call/ret decode) and instruction memory address.

---
 rtl/pc_ras_pkg.sv | 46 ++++
 rtl/pc_ras_if.sv | 33 +++
 rtl/pc_ras_ras_stack.sv | 91 +++++++++
 rtl/pc_ras.sv | 126 ++++++++++++
 tb/tb_pc_ras.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_ras_pkg.sv
// Shared definitions for the program counter with return-address stack:
// default geometry, reset value and the one-hot-free action encoding used
// by both the decode logic and anything that needs to reason about it.
package pc_ras_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_RESET_VAL = 0;

  // One action per cycle, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    ACT_CLR  = 3'd0,
    ACT_LOAD = 3'd1,
    ACT_CALL = 3'd2,
    ACT_RET  = 3'd3,
    ACT_INC  = 3'd4,
    ACT_HOLD = 3'd5
  } action_t;

  // Priority encoder: clr > load > call > ret > inc > hold.
  // Lower-priority requests in the same cycle are simply dropped.
  function automatic action_t decode_action(
    input logic clr,
    input logic load,
    input logic call,
    input logic ret,
    input logic inc
  );
    action_t act;
    if (clr) begin
      act = ACT_CLR;
    end else if (load) begin
      act = ACT_LOAD;
    end else if (call) begin
      act = ACT_CALL;
    end else if (ret) begin
      act = ACT_RET;
    end else if (inc) begin
      act = ACT_INC;
    end else begin
      act = ACT_HOLD;
    end
    return act;
  endfunction

endpackage

// File: rtl/pc_ras_if.sv
// Control/status bundle between the control unit (master) and the
// program-counter block (slave).
interface pc_ras_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);

  logic                         clr;
  logic                         load;
  logic [WIDTH-1:0]             load_val;
  logic                         call;
  logic [WIDTH-1:0]             call_target;
  logic                         ret;
  logic                         inc;
  logic [WIDTH-1:0]             pc_out;
  logic [$clog2(DEPTH+1)-1:0]   depth;
  logic                         empty;
  logic                         full;
  logic                         ovf;
  logic                         unf;
  logic                         wrap;

  modport master (
    output clr, load, load_val, call, call_target, ret, inc,
    input  pc_out, depth, empty, full, ovf, unf, wrap
  );

  modport slave (
    input  clr, load, load_val, call, call_target, ret, inc,
    output pc_out, depth, empty, full, ovf, unf, wrap
  );

endinterface

// File: rtl/pc_ras_ras_stack.sv
// Circular LIFO for return addresses. A push while full overwrites the
// oldest entry, so the newest DEPTH addresses are always retained.
// Count, full and empty are registered; the top entry is read from the
// storage array at the slot just below the write pointer.
module ras_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] wr_ptr_next_s;
  logic [PTR_W-1:0] top_idx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             full_r;
  logic             empty_r;
  logic             full_next_s;
  logic             empty_next_s;
  logic             wr_en_s;

  // Pointer/count update: flush wins over push, push wins over pop.
  always_comb begin
    wr_ptr_next_s = wr_ptr_r;
    cnt_next_s    = cnt_r;
    wr_en_s       = 1'b0;
    if (flush) begin
      wr_ptr_next_s = {PTR_W{1'b0}};
      cnt_next_s    = {CNT_W{1'b0}};
    end else if (push) begin
      wr_en_s       = 1'b1;
      wr_ptr_next_s = wr_ptr_r + PTR_W'(1'b1);
      if (full_r) begin
        cnt_next_s = cnt_r;
      end else begin
        cnt_next_s = cnt_r + CNT_W'(1'b1);
      end
    end else if (pop && !empty_r) begin
      wr_ptr_next_s = wr_ptr_r - PTR_W'(1'b1);
      cnt_next_s    = cnt_r - CNT_W'(1'b1);
    end else begin
      wr_ptr_next_s = wr_ptr_r;
      cnt_next_s    = cnt_r;
    end
    full_next_s  = (cnt_next_s == CNT_W'(DEPTH));
    empty_next_s = (cnt_next_s == {CNT_W{1'b0}});
  end

  // Pointer, count and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      wr_ptr_r <= wr_ptr_next_s;
      cnt_r    <= cnt_next_s;
      full_r   <= full_next_s;
      empty_r  <= empty_next_s;
    end
  end

  // Entry storage; contents are meaningless once the count says empty.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign top_idx_s = wr_ptr_r - PTR_W'(1'b1);
  assign top       = mem_r[top_idx_s];
  assign depth     = cnt_r;
  assign full      = full_r;
  assign empty     = empty_r;

endmodule

// File: rtl/pc_ras.sv
// Program counter with integrated return-address stack for the fetch
// stage. One action per cycle (clr > load > call > ret > inc > hold);
// all outputs come straight from registers.
module pc_ras
  import pc_ras_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
  input  logic      clk,
  input  logic      rst_n,
  pc_ras_if.slave   bus
);

  action_t          act_s;
  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_next_s;
  logic [WIDTH-1:0] pc_inc_s;
  logic             pc_max_s;
  logic             ovf_r;
  logic             unf_r;
  logic             wrap_r;
  logic             ovf_next_s;
  logic             unf_next_s;
  logic             wrap_next_s;
  logic             push_s;
  logic             pop_s;
  logic             flush_s;
  logic [WIDTH-1:0] stk_top_s;
  logic             stk_full_s;
  logic             stk_empty_s;

  assign act_s    = decode_action(bus.clr, bus.load, bus.call, bus.ret, bus.inc);
  // Shared incrementer: feeds both inc and the return address of call.
  assign pc_inc_s = pc_r + WIDTH'(1'b1);
  assign pc_max_s = (pc_r == {WIDTH{1'b1}});

  // Next-state decode for PC, stack controls and sticky/pulse flags.
  always_comb begin
    pc_next_s   = pc_r;
    ovf_next_s  = ovf_r;
    unf_next_s  = unf_r;
    wrap_next_s = 1'b0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    flush_s     = 1'b0;
    case (act_s)
      ACT_CLR: begin
        pc_next_s  = RESET_VAL;
        flush_s    = 1'b1;
        ovf_next_s = 1'b0;
        unf_next_s = 1'b0;
      end
      ACT_LOAD: begin
        pc_next_s = bus.load_val;
      end
      ACT_CALL: begin
        push_s    = 1'b1;
        pc_next_s = bus.call_target;
        if (stk_full_s) begin
          ovf_next_s = 1'b1;
        end else begin
          ovf_next_s = ovf_r;
        end
      end
      ACT_RET: begin
        if (stk_empty_s) begin
          unf_next_s = 1'b1;
        end else begin
          pop_s     = 1'b1;
          pc_next_s = stk_top_s;
        end
      end
      ACT_INC: begin
        pc_next_s   = pc_inc_s;
        wrap_next_s = pc_max_s;
      end
      ACT_HOLD: begin
        pc_next_s = pc_r;
      end
      default: begin
        pc_next_s = pc_r;
      end
    endcase
  end

  // PC and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r   <= RESET_VAL;
      ovf_r  <= 1'b0;
      unf_r  <= 1'b0;
      wrap_r <= 1'b0;
    end else begin
      pc_r   <= pc_next_s;
      ovf_r  <= ovf_next_s;
      unf_r  <= unf_next_s;
      wrap_r <= wrap_next_s;
    end
  end

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_s),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_inc_s),
    .top       (stk_top_s),
    .depth     (bus.depth),
    .full      (stk_full_s),
    .empty     (stk_empty_s)
  );

  assign bus.pc_out = pc_r;
  assign bus.full   = stk_full_s;
  assign bus.empty  = stk_empty_s;
  assign bus.ovf    = ovf_r;
  assign bus.unf    = unf_r;
  assign bus.wrap   = wrap_r;

endmodule

// File: tb/tb_pc_ras.sv
// Bench for pc_ras: directed scenarios followed by random request mixes,
// each cycle compared against a queue-based reference model.
module tb_pc_ras;

  localparam int W    = 16;
  localparam int D    = 8;
  localparam int MODV = 65536;

  logic clk;
  logic rst_n;

  pc_ras_if #(.WIDTH(W), .DEPTH(D)) bus ();

  pc_ras #(.WIDTH(W), .DEPTH(D), .RESET_VAL(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  int unsigned m_pc;
  int unsigned m_stk[$];
  bit          m_ovf;
  bit          m_unf;
  bit          m_wrap;

  task automatic model_reset();
    m_pc = 0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_wrap = 1'b0;
  endtask

  task automatic model_step(input bit c, input bit l, input int unsigned lv,
                            input bit ca, input int unsigned ct,
                            input bit r, input bit i);
    m_wrap = 1'b0;
    if (c) begin
      model_reset();
    end else if (l) begin
      m_pc = lv;
    end else if (ca) begin
      if (m_stk.size() == D) begin
        void'(m_stk.pop_front());
        m_ovf = 1'b1;
      end
      m_stk.push_back((m_pc + 1) % MODV);
      m_pc = ct;
    end else if (r) begin
      if (m_stk.size() == 0) m_unf = 1'b1;
      else m_pc = m_stk.pop_back();
    end else if (i) begin
      m_wrap = (m_pc == MODV - 1);
      m_pc = (m_pc + 1) % MODV;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    32'(bus.pc_out), m_pc);
    chk({tag, ".depth"}, 32'(bus.depth),  32'(m_stk.size()));
    chk({tag, ".empty"}, 32'(bus.empty),  32'(m_stk.size() == 0));
    chk({tag, ".full"},  32'(bus.full),   32'(m_stk.size() == D));
    chk({tag, ".ovf"},   32'(bus.ovf),    32'(m_ovf));
    chk({tag, ".unf"},   32'(bus.unf),    32'(m_unf));
    chk({tag, ".wrap"},  32'(bus.wrap),   32'(m_wrap));
  endtask

  // Apply one cycle of requests, then compare after the edge.
  task automatic step(input string tag, input bit c, input bit l, input int unsigned lv,
                      input bit ca, input int unsigned ct, input bit r, input bit i);
    bus.clr = c; bus.load = l; bus.load_val = lv[W-1:0];
    bus.call = ca; bus.call_target = ct[W-1:0]; bus.ret = r; bus.inc = i;
    @(posedge clk);
    #1;
    model_step(c, l, lv, ca, ct, r, i);
    check_all(tag);
    bus.clr = 1'b0; bus.load = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.inc = 1'b0;
  endtask

  task automatic do_inc(input string tag);  step(tag, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic do_load(input string tag, input int unsigned v); step(tag, 0, 1, v, 0, 0, 0, 0); endtask
  task automatic do_call(input string tag, input int unsigned t); step(tag, 0, 0, 0, 1, t, 0, 0); endtask
  task automatic do_ret(input string tag);  step(tag, 0, 0, 0, 0, 0, 1, 0); endtask
  task automatic do_clr(input string tag);  step(tag, 1, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    int unsigned nest_exp_pc[5];
    int unsigned nest_exp_d[5];
    bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = '0; bus.call = 1'b0;
    bus.call_target = '0; bus.ret = 1'b0; bus.inc = 1'b0;
    model_reset();
    rst_n = 1'b0;
    #22;
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-run: push something, then assert rst_n asynchronously.
    do_load("pre_rst_load", 16'h0030);
    do_call("pre_rst_call", 16'h0050);
    do_inc("pre_rst_inc");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    bus.inc = 1'b1; bus.call = 1'b1; bus.call_target = 16'h1234;
    @(posedge clk); #1;
    check_all("reset_held");
    bus.inc = 1'b0; bus.call = 1'b0;
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) do_inc("post_rst_inc");
    chk("five_incs_pc", 32'(bus.pc_out), 32'd5);
    do_clr("clr_after_incs");

    // Increment wrap
    do_load("wrap_load", 16'hFFFE);
    do_inc("wrap_inc1");
    chk("wrap_pc_ffff", 32'(bus.pc_out), 32'h0000FFFF);
    do_inc("wrap_inc2");
    chk("wrap_pulse", 32'(bus.wrap), 32'd1);
    step("wrap_hold", 0, 0, 0, 0, 0, 0, 0);
    chk("wrap_cleared", 32'(bus.wrap), 32'd0);

    // Call/return nesting
    nest_exp_pc = '{100, 101, 200, 102, 11};
    nest_exp_d  = '{1, 1, 2, 1, 0};
    do_clr("nest_clr");
    do_load("nest_load", 10);
    do_call("nest_call100", 100);
    chk("nest_pc0", 32'(bus.pc_out), nest_exp_pc[0]);
    chk("nest_d0", 32'(bus.depth), nest_exp_d[0]);
    do_inc("nest_inc");
    chk("nest_pc1", 32'(bus.pc_out), nest_exp_pc[1]);
    chk("nest_d1", 32'(bus.depth), nest_exp_d[1]);
    do_call("nest_call200", 200);
    chk("nest_pc2", 32'(bus.pc_out), nest_exp_pc[2]);
    chk("nest_d2", 32'(bus.depth), nest_exp_d[2]);
    do_ret("nest_ret1");
    chk("nest_pc3", 32'(bus.pc_out), nest_exp_pc[3]);
    chk("nest_d3", 32'(bus.depth), nest_exp_d[3]);
    do_ret("nest_ret2");
    chk("nest_pc4", 32'(bus.pc_out), nest_exp_pc[4]);
    chk("nest_d4", 32'(bus.depth), nest_exp_d[4]);

    // Push of all-ones stores 0 and does not pulse wrap
    do_load("push_max_load", 16'hFFFF);
    do_call("push_max_call", 16'h0777);
    do_ret("push_max_ret");
    chk("push_max_ret_pc", 32'(bus.pc_out), 32'd0);

    // Overflow
    do_clr("ovf_clr");
    for (int t = 1; t <= 9; t++) do_call("ovf_call", t);
    chk("ovf_flag", 32'(bus.ovf), 32'd1);
    chk("ovf_depth", 32'(bus.depth), 32'd8);
    for (int k = 0; k < 8; k++) begin
      do_ret("ovf_ret");
      chk("ovf_ret_lifo", 32'(bus.pc_out), 32'(9 - k));
    end
    do_ret("ovf_extra_ret");
    chk("ovf_then_unf", 32'(bus.unf), 32'd1);

    // Underflow
    do_clr("unf_clr");
    do_load("unf_load", 42);
    do_ret("unf_ret");
    chk("unf_pc_hold", 32'(bus.pc_out), 32'd42);
    for (int k = 0; k < 3; k++) do_inc("unf_inc");
    chk("unf_sticky", 32'(bus.unf), 32'd1);
    do_clr("unf_clear");

    // Priority
    do_call("prio_setup_call", 16'h0200);
    step("prio_load_all", 0, 1, 7, 1, 16'h0300, 1, 1);
    chk("prio_load_pc", 32'(bus.pc_out), 32'd7);
    step("prio_call_ret", 0, 0, 0, 1, 16'h0400, 1, 0);
    chk("prio_call_wins", 32'(bus.pc_out), 32'h400);
    step("prio_clr_all", 1, 1, 9, 1, 16'h0500, 1, 1);

    // Random request mixes against the model
    for (int n = 0; n < 600; n++) begin
      bit c, l, ca, r, i;
      int unsigned lv, ct;
      c  = ($urandom_range(0, 39) == 0);
      l  = ($urandom_range(0, 7) == 0);
      ca = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 2) == 0);
      i  = ($urandom_range(0, 1) == 0);
      lv = ($urandom_range(0, 7) == 0) ? 32'h0000FFFF : ($urandom() % MODV);
      ct = ($urandom_range(0, 7) == 0) ? 32'h0000FFFF : ($urandom() % MODV);
      step("rand", c, l, lv, ca, ct, r, i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
